spi_master_tx: RTL and testbench
================================

Name: spi_master_tx

Overview:
- SPI mode-0 initiator (CPOL=0, CPHA=0) that serialises parallel words onto sck_o/mosi_o/cs_n_o, MSB first.
- Drives the async pins that the SPI receiver's three-flop synchroniser samples, so all pin timing is expressed in whole sysClk cycles and stays slow enough for edge detection.
- The processor-side register block feeds it through a ready/start handshake.
- Supports single words and back-to-back words under one CS assertion.

Parameters:
- DATA_WIDTH, 8: bits per word.
- CLK_DIV, 4: sysClk cycles per SCK half-period. Legal range is 3 or more (elaboration error otherwise), so an equal-rate receiver synchroniser sees each SCK level for at least 3 samples.

Ports:
- sysClk_i  in  1  system clock; all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  request; accepted only when ready_o=1.
- data_i  in  DATA_WIDTH  word to send; captured on acceptance.
- cont_i  in  1  captured on acceptance; 1 keeps CS asserted after the word.
- ready_o  out  1  block can accept start_i this cycle.
- done_o  out  1  one-cycle pulse when a word's last SCK high phase completes.
- sck_o  out  1  SPI clock, idle low.
- mosi_o  out  1  serial data.
- cs_n_o  out  1  chip select, active low.

Behaviour:
- All outputs are registered.
- Reset values (asserted asynchronously, effective immediately): cs_n_o=1, sck_o=0, mosi_o=0, ready_o=1, done_o=0; FSM=IDLE; divider and bit counter = 0.
- Mid-transfer reset aborts at once: CS rises, SCK drops, and no done_o pulse is issued.
- FSM states: IDLE, LOW, HIGH, HOLD, GAP, CONT.
- Acceptance happens in a cycle with start_i=1 and ready_o=1 (call it cycle 0).
  - Capture data_i into the shift register, capture cont_i, and set the bit counter to DATA_WIDTH-1.
  - ready_o drops in cycle 1.
- Cycle 1, entering LOW: cs_n_o=0, sck_o=0, mosi_o=data_i[MSB].
- LOW and HIGH each last exactly CLK_DIV cycles.
  - LOW→HIGH: sck_o rises; MOSI is unchanged.
  - HIGH→LOW with bits remaining: sck_o falls and mosi_o takes the next bit in the same cycle.
- The first LOW doubles as CS setup, so CS leads the first rising SCK by CLK_DIV cycles.
- After the final HIGH phase, done_o=1 for exactly one cycle (cycle 2·DATA_WIDTH·CLK_DIV+1) and sck_o falls.
  - cont=0: enter HOLD (CLK_DIV cycles, CS low, MOSI holds last bit). Then GAP: cs_n_o=1, mosi_o=0 for CLK_DIV cycles. Then IDLE with ready_o=1.
  - cont=1: enter CONT with CS still low, SCK low, ready_o=1.
- In CONT:
  - start_i is accepted like in IDLE and goes directly to LOW with the new MSB, with no CS toggle.
  - A start_i that arrives in the same cycle CONT is entered is accepted on the next cycle, once ready_o=1.
  - The block stays in CONT indefinitely until the next start_i.
  - Software terminates a burst by sending the final word with cont_i=0.
- ready_o=1 only in IDLE and CONT. start_i while ready_o=0 is ignored, not queued.
- The divider counter counts 0..CLK_DIV-1 and resets on every phase change. The bit counter decrements on HIGH→LOW and stops at 0.
- For D=CLK_DIV, N=DATA_WIDTH, a single non-continued word runs as:
  - cs_n_o low for cycles 1..(2N+1)D;
  - done_o at cycle 2ND+1;
  - ready_o high again at cycle (2N+2)D+1.

Test Plan:
- Reset then idle: hold rst_ni=0 for 3 cycles, release → cs_n_o=1, sck_o=0, mosi_o=0, ready_o=1, done_o=0; unchanged with start_i=0 for 20 cycles.
- Single word 0xA5, cont=0, D=4 → cs_n_o falls at cycle 1; 8 SCK rising edges at cycles 5,13,…,61; MOSI sampled at each rising edge reads 1,0,1,0,0,1,0,1; done_o only at cycle 65; cs_n_o high at cycle 69; ready_o high at cycle 73.
- Burst 0x3C (cont=1) then 0xFF (cont=0), second start issued on the first ready cycle → CS stays low across both words; 16 SCK rising edges; two done_o pulses; slave model receives 0x3C, 0xFF.
- Start while busy: pulse start_i with 0x00 at cycle 20 of a 0x81 transfer → ignored; exactly 8 SCK edges; only 0x81 received.
- Reset mid-word: assert rst_ni low during bit 3's HIGH phase → cs_n_o=1, sck_o=0 in the same cycle; no done_o; a subsequent 0x5A transfers correctly.
- Receiver loopback: drive sck_o/mosi_o/cs_n_o into the SPI receiver (with its three-flop synchroniser) on the same sysClk, CLK_DIV=3 → 256 random words received bit-exact.

Source files
------------

// File: rtl/spi_master_tx.sv
// SPI mode-0 initiator: serialises DATA_WIDTH-bit words MSB first on sck_o/mosi_o/cs_n_o,
// with every pin registered and all timing in whole sysClk cycles.
module spi_master_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  sysClk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  cont_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic                  sck_o,
    output logic                  mosi_o,
    output logic                  cs_n_o,
    output logic [2:0]            state_o
);

    // Handshake: a word is taken on any rising edge where start_i=1 and ready_o=1;
    // start_i while ready_o=0 is dropped, never queued.

    if (CLK_DIV < 3) begin : g_div_check
        $error("spi_master_tx: CLK_DIV must be 3 or more");
    end
    if (DATA_WIDTH < 2) begin : g_width_check
        $error("spi_master_tx: DATA_WIDTH must be 2 or more");
    end

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int SH_W  = DATA_WIDTH - 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOW  = 3'd1,
        ST_HIGH = 3'd2,
        ST_HOLD = 3'd3,
        ST_GAP  = 3'd4,
        ST_CONT = 3'd5
    } state_t;

    state_t            state_q, state_n;
    logic [DIV_W-1:0]  div_q, div_n;
    logic [BIT_W-1:0]  bit_q, bit_n;
    // The MSB goes straight to mosi on acceptance, so only the remaining bits are kept.
    logic [SH_W-1:0]   sh_q, sh_n;
    logic              cont_q, cont_n;
    logic              ready_q, ready_n;
    logic              done_q, done_n;
    logic              sck_q, sck_n;
    logic              mosi_q, mosi_n;
    logic              cs_n_q, cs_n_n;
    logic              phase_end;

    assign phase_end = (div_q == DIV_LAST);

    always_ff @(posedge sysClk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            cont_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_n;
            div_q   <= div_n;
            bit_q   <= bit_n;
            sh_q    <= sh_n;
            cont_q  <= cont_n;
            ready_q <= ready_n;
            done_q  <= done_n;
            sck_q   <= sck_n;
            mosi_q  <= mosi_n;
            cs_n_q  <= cs_n_n;
        end
    end

    always_comb begin
        state_n = state_q;
        div_n   = div_q;
        bit_n   = bit_q;
        sh_n    = sh_q;
        cont_n  = cont_q;
        ready_n = ready_q;
        done_n  = 1'b0;
        sck_n   = sck_q;
        mosi_n  = mosi_q;
        cs_n_n  = cs_n_q;

        unique case (state_q)
            ST_IDLE, ST_CONT: begin
                div_n = '0;
                if (start_i) begin
                    state_n = ST_LOW;
                    bit_n   = BIT_LAST;
                    sh_n    = data_i[SH_W-1:0];
                    cont_n  = cont_i;
                    ready_n = 1'b0;
                    cs_n_n  = 1'b0;
                    sck_n   = 1'b0;
                    mosi_n  = data_i[DATA_WIDTH-1];
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    state_n = ST_HIGH;
                    div_n   = '0;
                    sck_n   = 1'b1;
                end else begin
                    div_n = div_q + DIV_W'(1);
                end
            end
            ST_HIGH: begin
                if (!phase_end) begin
                    div_n = div_q + DIV_W'(1);
                end else if (bit_q != '0) begin
                    state_n = ST_LOW;
                    div_n   = '0;
                    bit_n   = bit_q - BIT_W'(1);
                    sh_n    = sh_q << 1;
                    sck_n   = 1'b0;
                    mosi_n  = sh_q[SH_W-1];
                end else begin
                    // Last bit done: either park with CS low for the next word, or wind down.
                    div_n   = '0;
                    sck_n   = 1'b0;
                    done_n  = 1'b1;
                    if (cont_q) begin
                        state_n = ST_CONT;
                        ready_n = 1'b1;
                    end else begin
                        state_n = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (phase_end) begin
                    state_n = ST_GAP;
                    div_n   = '0;
                    cs_n_n  = 1'b1;
                    mosi_n  = 1'b0;
                end else begin
                    div_n = div_q + DIV_W'(1);
                end
            end
            ST_GAP: begin
                if (phase_end) begin
                    state_n = ST_IDLE;
                    div_n   = '0;
                    ready_n = 1'b1;
                end else begin
                    div_n = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                div_n   = '0;
                ready_n = 1'b1;
                cs_n_n  = 1'b1;
                sck_n   = 1'b0;
                mosi_n  = 1'b0;
            end
        endcase
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign sck_o   = sck_q;
    assign mosi_o  = mosi_q;
    assign cs_n_o  = cs_n_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: a CLK_DIV=4 instance checked cycle-by-cycle against a timeline
// model, and a CLK_DIV=3 instance looped into a synchronised SPI receiver.
module tb_spi_master_tx;

    localparam int N  = 8;
    localparam int D4 = 4;
    localparam int D3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start4 = 1'b0, cont4 = 1'b0;
    logic [N-1:0] data4 = '0;
    logic         ready4, done4, sck4, mosi4, cs4;
    logic [2:0]   state4;

    logic         start3 = 1'b0, cont3 = 1'b0;
    logic [N-1:0] data3 = '0;
    logic         ready3, done3, sck3, mosi3, cs3;
    logic [2:0]   state3;

    spi_master_tx #(.DATA_WIDTH(N), .CLK_DIV(D4)) dut4 (
        .sysClk_i(clk), .rst_ni(rst_n), .start_i(start4), .data_i(data4), .cont_i(cont4),
        .ready_o(ready4), .done_o(done4), .sck_o(sck4), .mosi_o(mosi4), .cs_n_o(cs4),
        .state_o(state4)
    );

    spi_master_tx #(.DATA_WIDTH(N), .CLK_DIV(D3)) dut3 (
        .sysClk_i(clk), .rst_ni(rst_n), .start_i(start3), .data_i(data3), .cont_i(cont3),
        .ready_o(ready3), .done_o(done3), .sck_o(sck3), .mosi_o(mosi3), .cs_n_o(cs3),
        .state_o(state3)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {cs_n, sck, mosi, ready, done} t cycles after acceptance, from the word timeline.
    function automatic logic [4:0] exp_pins(input int t, input logic [N-1:0] d, input bit c, input int dv);
        int k, ph;
        if (t <= 2 * N * dv) begin
            k  = (t - 1) / (2 * dv);
            ph = (t - 1) % (2 * dv);
            return {1'b0, ph >= dv, d[N-1-k], 1'b0, 1'b0};
        end
        if (c) return {1'b0, 1'b0, d[0], 1'b1, t == 2 * N * dv + 1};
        if (t <= (2 * N + 1) * dv) return {1'b0, 1'b0, d[0], 1'b0, t == 2 * N * dv + 1};
        if (t <= (2 * N + 2) * dv) return 5'b10000;
        return 5'b10010;
    endfunction

    // MOSI is left unconstrained while parked between burst words.
    function automatic logic [4:0] pin_mask(input int t, input bit c, input int dv);
        return (c && t > 2 * N * dv) ? 5'b11011 : 5'b11111;
    endfunction

    // Receiver model for dut4: samples pins directly, one bit per rising SCK with CS low.
    logic [N-1:0] exp_q4[$];
    logic [N-1:0] rx4_sh = '0;
    int           rx4_cnt = 0, n_rise4 = 0, n_rx4 = 0, n_push4 = 0;
    logic         prev_sck4 = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx4_cnt   = 0;
            prev_sck4 = 1'b0;
        end else begin
            if (cs4) begin
                rx4_cnt = 0;
            end else if (sck4 && !prev_sck4) begin
                rx4_sh = {rx4_sh[N-2:0], mosi4};
                rx4_cnt++;
                n_rise4++;
                if (rx4_cnt == N) begin
                    rx4_cnt = 0;
                    n_rx4++;
                    if (exp_q4.size() == 0) check("rx4_extra", 32'(n_rx4), 32'(n_push4));
                    else                    check("rx4_word", 32'(rx4_sh), 32'(exp_q4.pop_front()));
                end
            end
            prev_sck4 = sck4;
        end
    end

    // Receiver for dut3 behind a three-flop synchroniser on each pin.
    logic [N-1:0] exp_q3[$];
    logic [N-1:0] rx3_sh = '0;
    logic [2:0]   s_sck = '0, s_mosi = '0, s_cs = '1;
    int           rx3_cnt = 0, n_rx3 = 0, n_push3 = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            s_sck   = '0;
            s_mosi  = '0;
            s_cs    = '1;
            rx3_cnt = 0;
        end else begin
            if (s_cs[1]) begin
                rx3_cnt = 0;
            end else if (s_sck[1] && !s_sck[2]) begin
                rx3_sh = {rx3_sh[N-2:0], s_mosi[1]};
                rx3_cnt++;
                if (rx3_cnt == N) begin
                    rx3_cnt = 0;
                    n_rx3++;
                    if (exp_q3.size() == 0) check("rx3_extra", 32'(n_rx3), 32'(n_push3));
                    else                    check("rx3_word", 32'(rx3_sh), 32'(exp_q3.pop_front()));
                end
            end
            s_sck  = {s_sck[1:0], sck3};
            s_mosi = {s_mosi[1:0], mosi3};
            s_cs   = {s_cs[1:0], cs3};
        end
    end

    // One dut4 word: start in the current cycle, check pins for cycles 1..last_t.
    // poke_t pulses a stray start (data 0) in that cycle; abort_t asserts reset in that cycle.
    task automatic xfer(input logic [N-1:0] d, input bit c, input int last_t,
                        input int poke_t, input int abort_t);
        logic [4:0] pins, e, m;
        check("accept_ready", 32'(ready4), 32'd1);
        data4  = d;
        cont4  = c;
        start4 = 1'b1;
        if (abort_t < 0) begin
            exp_q4.push_back(d);
            n_push4++;
        end
        for (int t = 1; t <= last_t; t++) begin
            tick();
            start4 = (t == poke_t);
            if (t == poke_t) data4 = '0;
            pins = {cs4, sck4, mosi4, ready4, done4};
            e    = exp_pins(t, d, c, D4);
            m    = pin_mask(t, c, D4);
            check("pins", 32'(pins & m), 32'(e & m));
            if (t == abort_t) begin
                rst_n = 1'b0;
                #1;
                check("abort_pins", 32'({cs4, sck4, mosi4, ready4, done4}), 32'h12);
                return;
            end
        end
        start4 = 1'b0;
    endtask

    initial begin
        #500_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        logic [N-1:0] d;
        bit           c;

        rst_n = 1'b0;
        repeat (3) tick();
        check("rst4", 32'({cs4, sck4, mosi4, ready4, done4}), 32'h12);
        check("rst3", 32'({cs3, sck3, mosi3, ready3, done3}), 32'h12);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle", 32'({cs4, sck4, mosi4, ready4, done4}), 32'h12);
        end

        n_rise4 = 0;
        xfer(8'hA5, 1'b0, (2 * N + 2) * D4 + 1, -1, -1);
        check("edges_single", 32'(n_rise4), 32'd8);

        n_rise4 = 0;
        xfer(8'h3C, 1'b1, 2 * N * D4 + 1, -1, -1);
        xfer(8'hFF, 1'b0, (2 * N + 2) * D4 + 1, -1, -1);
        check("edges_burst", 32'(n_rise4), 32'd16);

        n_rise4 = 0;
        xfer(8'h81, 1'b0, (2 * N + 2) * D4 + 1, 20, -1);
        check("edges_busy", 32'(n_rise4), 32'd8);

        d = N'($urandom);
        xfer(d, 1'b0, 7 * D4 + 2, -1, 7 * D4 + 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold", 32'({cs4, sck4, mosi4, ready4, done4}), 32'h12);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst", 32'({cs4, sck4, mosi4, ready4, done4}), 32'h12);
        n_rise4 = 0;
        xfer(8'h5A, 1'b0, (2 * N + 2) * D4 + 1, -1, -1);
        check("edges_post_rst", 32'(n_rise4), 32'd8);

        for (int i = 0; i < 8; i++) begin
            c = (i == 7) ? 1'b0 : 1'($urandom_range(0, 1));
            d = N'($urandom);
            xfer(d, c, c ? 2 * N * D4 + 1 : (2 * N + 2) * D4 + 1, -1, -1);
        end
        check("rx4_left", 32'(exp_q4.size()), 32'd0);

        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 200 && !ready3; k++) tick();
            check("ready3_wait", 32'(ready3), 32'd1);
            d      = N'($urandom);
            data3  = d;
            cont3  = (i == 255) ? 1'b0 : 1'($urandom_range(0, 1));
            start3 = 1'b1;
            exp_q3.push_back(d);
            n_push3++;
            tick();
            start3 = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        for (int k = 0; k < 400 && !(ready3 && cs3); k++) tick();
        check("idle3_wait", 32'({ready3, cs3}), 32'h3);
        repeat (8) tick();
        check("rx3_left", 32'(exp_q3.size()), 32'd0);
        check("rx3_total", 32'(n_rx3), 32'd256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
